// File: rtl/suma.sv
// suma: decimal addition engine for the keypad calculator.
// Builds two operands of up to four decimal digits from decoded key pulses
// and produces their binary sum, clamped to the 9999 display limit.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   key_code     0-9 digit, 10 ADD, 11 EQUAL, 12 CLEAR, 13-15 ignored
//   key_pulse    one press per high cycle
//   result       operand being entered, or the computed sum
//   result_valid result holds a computed sum
//   result_pulse one-cycle strobe when a new sum is produced
//   overflow     last computed sum exceeded 9999
module suma (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_pulse,
    output logic [13:0] result,
    output logic        result_valid,
    output logic        result_pulse,
    output logic        overflow
);

    localparam int unsigned RES_W = 14;
    localparam int unsigned SUM_W = 15;
    localparam int unsigned CNT_W = 3;

    localparam logic [RES_W-1:0] DISP_MAX   = 14'd9999;
    localparam logic [CNT_W-1:0] MAX_DIGITS = 3'd4;

    localparam logic [3:0] KEY_ADD   = 4'd10;
    localparam logic [3:0] KEY_EQUAL = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd12;

    localparam logic [1:0] ENTER_A = 2'd0;
    localparam logic [1:0] ENTER_B = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [RES_W-1:0] op_a, op_a_nxt;
    logic [RES_W-1:0] op_b, op_b_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RES_W-1:0] result_nxt;
    logic             result_valid_nxt;
    logic             result_pulse_nxt;
    logic             overflow_nxt;

    logic             is_digit;
    logic [RES_W-1:0] digit;
    logic [RES_W-1:0] cur_op;
    logic [RES_W-1:0] entry_val;
    logic [SUM_W-1:0] sum_c;

    // Shared datapath: digit append on the active operand and the full-width sum
    assign is_digit  = (key_code <= 4'd9);
    assign digit     = RES_W'(key_code);
    assign cur_op    = (state == ENTER_B) ? op_b : op_a;
    // cur_op is at most 999 whenever a digit is appended, so 14 bits suffice
    assign entry_val = (cur_op * RES_W'(10)) + digit;
    assign sum_c     = SUM_W'(op_a) + SUM_W'(op_b);

    // State, operand and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ENTER_A;
            op_a         <= '0;
            op_b         <= '0;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_pulse <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            op_a         <= op_a_nxt;
            op_b         <= op_b_nxt;
            cnt          <= cnt_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            result_pulse <= result_pulse_nxt;
            overflow     <= overflow_nxt;
        end
    end

    // Key decode and next-state logic
    always_comb begin
        state_nxt        = state;
        op_a_nxt         = op_a;
        op_b_nxt         = op_b;
        cnt_nxt          = cnt;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        result_pulse_nxt = 1'b0;
        overflow_nxt     = overflow;

        if (key_pulse) begin
            if (is_digit) begin
                case (state)
                    ENTER_A, ENTER_B: begin
                        // digits beyond the fourth are dropped
                        if (cnt < MAX_DIGITS) begin
                            if (state == ENTER_A) op_a_nxt = entry_val;
                            else                  op_b_nxt = entry_val;
                            cnt_nxt    = cnt + 3'd1;
                            result_nxt = entry_val;
                        end
                    end
                    DONE: begin
                        // a digit after a result starts a fresh calculation
                        op_a_nxt         = digit;
                        op_b_nxt         = '0;
                        cnt_nxt          = 3'd1;
                        result_nxt       = digit;
                        result_valid_nxt = 1'b0;
                        overflow_nxt     = 1'b0;
                        state_nxt        = ENTER_A;
                    end
                    default: state_nxt = ENTER_A;
                endcase
            end else begin
                case (key_code)
                    KEY_ADD: begin
                        if (state == ENTER_A) begin
                            op_b_nxt   = '0;
                            cnt_nxt    = '0;
                            result_nxt = '0;
                            state_nxt  = ENTER_B;
                        end else if (state == DONE) begin
                            // chain: the displayed (clamped) sum becomes operand A
                            op_a_nxt         = result;
                            op_b_nxt         = '0;
                            cnt_nxt          = '0;
                            result_nxt       = '0;
                            result_valid_nxt = 1'b0;
                            overflow_nxt     = 1'b0;
                            state_nxt        = ENTER_B;
                        end
                    end
                    KEY_EQUAL: begin
                        if (state == ENTER_B) begin
                            if (sum_c > SUM_W'(DISP_MAX)) begin
                                result_nxt   = DISP_MAX;
                                overflow_nxt = 1'b1;
                            end else begin
                                result_nxt   = RES_W'(sum_c);
                                overflow_nxt = 1'b0;
                            end
                            result_valid_nxt = 1'b1;
                            result_pulse_nxt = 1'b1;
                            state_nxt        = DONE;
                        end
                    end
                    KEY_CLEAR: begin
                        op_a_nxt         = '0;
                        op_b_nxt         = '0;
                        cnt_nxt          = '0;
                        result_nxt       = '0;
                        result_valid_nxt = 1'b0;
                        overflow_nxt     = 1'b0;
                        state_nxt        = ENTER_A;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_suma.sv
// tb_suma: scoreboard bench for suma. Each driven cycle pushes the expected
// outputs from a behavioural calculator model; a monitor pops and compares.
module tb_suma;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic [13:0] result;
    logic        result_valid;
    logic        result_pulse;
    logic        overflow;

    suma dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_pulse    (key_pulse),
        .result       (result),
        .result_valid (result_valid),
        .result_pulse (result_pulse),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] res;
        logic        valid;
        logic        pulse;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Calculator model: mode 0 entering A, 1 entering B, 2 showing a sum
    int unsigned m_mode, m_a, m_b, m_n, m_res;
    bit          m_valid, m_ovf, m_pulse;

    function automatic void model_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_n = 0; m_res = 0;
        m_valid = 0; m_ovf = 0; m_pulse = 0;
    endfunction

    function automatic void model_key(input int unsigned k);
        int unsigned s;
        m_pulse = 0;
        if (k <= 9) begin
            if (m_mode == 2) begin
                m_a = k; m_b = 0; m_n = 1; m_res = k;
                m_valid = 0; m_ovf = 0; m_mode = 0;
            end else if (m_n < 4) begin
                if (m_mode == 0) begin m_a = m_a * 10 + k; m_res = m_a; end
                else             begin m_b = m_b * 10 + k; m_res = m_b; end
                m_n++;
            end
        end else if (k == 10) begin
            if (m_mode == 0) begin
                m_b = 0; m_n = 0; m_res = 0; m_mode = 1;
            end else if (m_mode == 2) begin
                m_a = m_res; m_b = 0; m_n = 0; m_res = 0;
                m_valid = 0; m_ovf = 0; m_mode = 1;
            end
        end else if (k == 11) begin
            if (m_mode == 1) begin
                s = m_a + m_b;
                m_ovf   = (s > 9999);
                m_res   = m_ovf ? 9999 : s;
                m_valid = 1; m_pulse = 1; m_mode = 2;
            end
        end else if (k == 12) begin
            m_a = 0; m_b = 0; m_n = 0; m_res = 0;
            m_valid = 0; m_ovf = 0; m_mode = 0;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.res = 14'(m_res); e.valid = m_valid; e.pulse = m_pulse; e.ovf = m_ovf;
        return e;
    endfunction

    // Monitor: compares every cycle that has a pending expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (result !== e.res || result_valid !== e.valid ||
                result_pulse !== e.pulse || overflow !== e.ovf) begin
                bad++;
                $display("FAIL cycle_check t=%0t got res=%0d v=%0b p=%0b o=%0b want res=%0d v=%0b p=%0b o=%0b",
                         $time, result, result_valid, result_pulse, overflow,
                         e.res, e.valid, e.pulse, e.ovf);
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_pulse = 1'b1;
        model_key(32'(k));
        sb.push_back(model_out());
    endtask

    task automatic idle();
        @(negedge clk);
        key_pulse = 1'b0;
        key_code  = 4'($urandom);
        m_pulse   = 0;
        sb.push_back(model_out());
    endtask

    // Direct check against a constant once the previous key has settled
    task automatic check_now(input string name, input int unsigned r,
                             input bit v, input bit o);
        idle();
        total++;
        if (result !== 14'(r) || result_valid !== v || overflow !== o) begin
            bad++;
            $display("FAIL %s got res=%0d v=%0b o=%0b want res=%0d v=%0b o=%0b",
                     name, result, result_valid, overflow, r, v, o);
        end
    endtask

    task automatic do_reset(input string name);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (result !== 14'd0 || result_valid !== 1'b0 ||
            result_pulse !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL %s got res=%0d v=%0b p=%0b o=%0b want all zero",
                     name, result, result_valid, result_pulse, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1; key_pulse = 1'b0; key_code = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if (result !== 14'd0 || result_valid !== 1'b0 ||
            result_pulse !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got res=%0d v=%0b p=%0b o=%0b want all zero",
                     result, result_valid, result_pulse, overflow);
        end
        rst = 1'b0;

        // 15 + 27
        press(4'd1); press(4'd5); press(4'd10); press(4'd2); press(4'd7); press(4'd11);
        check_now("sum_42", 42, 1, 0);
        idle();
        press(4'd12);
        check_now("clear", 0, 0, 0);
        press(4'd3); press(4'd10); press(4'd4); press(4'd11);
        check_now("sum_7", 7, 1, 0);

        // fifth digit ignored, then overflow clamp
        press(4'd12);
        repeat (5) press(4'd9);
        check_now("entry_9999", 9999, 0, 0);
        press(4'd10); press(4'd1); press(4'd11);
        check_now("overflow", 9999, 1, 1);

        // chaining and repeated EQUAL
        press(4'd1); press(4'd0); press(4'd10); press(4'd5); press(4'd11);
        check_now("chain_15", 15, 1, 0);
        press(4'd10); press(4'd5); press(4'd11);
        check_now("chain_20", 20, 1, 0);
        press(4'd11);
        check_now("equal_in_done", 20, 1, 0);

        // empty operands, EQUAL in ENTER_A, ignored codes in each state
        press(4'd12); press(4'd11);
        press(4'd13); press(4'd10); press(4'd14); press(4'd11); press(4'd15);
        check_now("empty_sum", 0, 1, 0);
        press(4'd6); press(4'd13); press(4'd14); press(4'd15);
        check_now("ignored_codes", 6, 0, 0);

        // reset mid-entry
        press(4'd1); press(4'd2); press(4'd10); press(4'd3);
        do_reset("reset_mid_entry");
        press(4'd2); press(4'd10); press(4'd2); press(4'd11);
        check_now("sum_4", 4, 1, 0);

        // randomized key stream
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 110)      press(4'($urandom_range(0, 9)));
            else if (r < 130) press(4'd10);
            else if (r < 155) press(4'd11);
            else if (r < 163) press(4'd12);
            else if (r < 175) press(4'($urandom_range(13, 15)));
            else if (r < 198) idle();
            else              do_reset("reset_random");
        end

        repeat (3) idle();
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
